// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the CPU and external requesters.
// DMEM_ARB_RR_EN selects round-robin tie breaking; default is CPU priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ext_req_i,
  input  owner_e last_own_i,
  output logic   cpu_win_c_o,
  output logic   ext_win_c_o
);

`ifdef DMEM_ARB_RR_EN
  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    cpu_win_c_o = 1'b0;
    ext_win_c_o = 1'b0;
    if (cpu_req_i && ext_req_i) begin
      cpu_win_c_o = (last_own_i == OWN_EXT);
      ext_win_c_o = (last_own_i == OWN_CPU);
    end else begin
      cpu_win_c_o = cpu_req_i;
      ext_win_c_o = ext_req_i;
    end
  end
`else
  logic unused_last_own;

  assign unused_last_own = last_own_i;
  assign cpu_win_c_o     = cpu_req_i;
  assign ext_win_c_o     = ext_req_i & ~cpu_req_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported data memory.
// Optional round-robin tie breaking via DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_c_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_c_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be in 1..4");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic              mem_wr_q, mem_wr_d;
  owner_e            last_own;
  logic              cpu_win_c, ext_win_c;

  dmem_arb_pick u_pick (
    .cpu_req_i   (cpu_req_i),
    .ext_req_i   (ext_req_i),
    .last_own_i  (last_own),
    .cpu_win_c_o (cpu_win_c),
    .ext_win_c_o (ext_win_c)
  );

`ifdef DMEM_ARB_RR_EN
  owner_e last_own_q, last_own_d;

  assign last_own_d = (cpu_gnt_c_o || ext_gnt_c_o) ? own_d : last_own_q;
  assign last_own   = last_own_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_own_q <= OWN_EXT;
    end else begin
      last_own_q <= last_own_d;
    end
  end
`else
  assign last_own = OWN_EXT;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      own_q        <= OWN_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      own_q        <= own_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  // Next-state logic; grants are only combinational outputs and only in IDLE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    own_d        = own_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    cpu_rvalid_d = 1'b0;
    ext_rvalid_d = 1'b0;
    mem_wr_d     = 1'b0;
    cpu_gnt_c_o  = 1'b0;
    ext_gnt_c_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset_ni && (cpu_win_c || ext_win_c)) begin
          state_d = BUSY;
          cnt_d   = '0;
          if (cpu_win_c) begin
            cpu_gnt_c_o = 1'b1;
            own_d       = OWN_CPU;
            we_d        = cpu_we_i;
            addr_d      = cpu_addr_i;
            wdata_d     = cpu_wdata_i;
          end else begin
            ext_gnt_c_o = 1'b1;
            own_d       = OWN_EXT;
            we_d        = ext_we_i;
            addr_d      = ext_addr_i;
            wdata_d     = ext_wdata_i;
          end
          mem_wr_d = we_d;
        end
      end
      BUSY: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
          if (own_q == OWN_CPU) begin
            cpu_rdata_d  = mem_rdata_i;
            cpu_rvalid_d = 1'b1;
          end else begin
            ext_rdata_d  = mem_rdata_i;
            ext_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rvalid_o = cpu_rvalid_q;
  assign ext_rvalid_o = ext_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign ext_rdata_o  = ext_rdata_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wr_o     = mem_wr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a read-response scoreboard.
module tb_dmem_arbiter;

  localparam int unsigned RD_LAT = 3;
  localparam int unsigned P      = RD_LAT + 2;
  localparam logic [63:0] D10    = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] D18    = 64'h1234_5678_9ABC_DEF0;

  typedef struct packed {
    logic        own;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        reset_ni;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [63:0] cpu_rdata, ext_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;
  logic [63:0] mem_m [16];
  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(RD_LAT)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_gnt_c_o  (cpu_gnt),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_rdata_o  (cpu_rdata),
    .ext_req_i    (ext_req),
    .ext_we_i     (ext_we),
    .ext_addr_i   (ext_addr),
    .ext_wdata_i  (ext_wdata),
    .ext_gnt_c_o  (ext_gnt),
    .ext_rvalid_o (ext_rvalid),
    .ext_rdata_o  (ext_rdata),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wr_o     (mem_wr),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data follows the held address within the first BUSY cycle.
  always @(posedge clk) if (mem_wr) mem_m[mem_addr[6:3]] <= mem_wdata;
  always @(negedge clk) mem_rdata <= mem_m[mem_addr[6:3]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    if (cpu_gnt || ext_gnt) chk("gnt_both", 64'(cpu_gnt & ext_gnt), 64'd0);
    if (cpu_rvalid || ext_rvalid) begin
      chk("rv_both", 64'(cpu_rvalid & ext_rvalid), 64'd0);
      if (exp_q.size() == 0) begin
        chk("rv_unexpected", 64'({cpu_rvalid, ext_rvalid}), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rv_owner", 64'(ext_rvalid), 64'(e.own));
        chk("rv_data", e.own ? ext_rdata : cpu_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic winner_ext;
    reset_ni = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (2) tick();
    smp();
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_rvalid", 64'({cpu_rvalid, ext_rvalid}), 64'd0);
    cpu_req = 1'b0;
    #2 reset_ni = 1'b1;

    // CPU write, then an EXT write in the first possible cycle
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = D10;
    smp();
    chk("wr_c0_cpu_gnt", 64'(cpu_gnt), 64'd1);
    chk("wr_c0_ext_gnt", 64'(ext_gnt), 64'd0);
    chk("wr_c0_mem_wr", 64'(mem_wr), 64'd0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    smp();
    chk("wr_c1_mem_wr", 64'(mem_wr), 64'd1);
    chk("wr_c1_mem_addr", mem_addr, 64'h10);
    chk("wr_c1_mem_wdata", mem_wdata, D10);
    chk("wr_c1_cpu_gnt", 64'(cpu_gnt), 64'd0);
    tick();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 64'h18; ext_wdata = D18;
    smp();
    chk("wr_c2_mem_wr", 64'(mem_wr), 64'd0);
    chk("wr_c2_ext_gnt", 64'(ext_gnt), 64'd1);
    tick();
    ext_req = 1'b0; ext_we = 1'b0;
    smp();
    chk("ewr_c1_mem_wr", 64'(mem_wr), 64'd1);
    chk("ewr_c1_mem_addr", mem_addr, 64'h18);

    // CPU read; EXT read raised while the CPU access is in flight
    tick();
    cpu_req = 1'b1; cpu_addr = 64'h10;
    smp();
    chk("rd_c0_cpu_gnt", 64'(cpu_gnt), 64'd1);
    exp_q.push_back('{own: 1'b0, data: D10});
    tick();
    cpu_req = 1'b0; ext_req = 1'b1; ext_addr = 64'h18;
    for (int c = 1; c <= int'(RD_LAT) + 1; c++) begin
      if (c > 1) tick();
      smp();
      chk("rd_wait_gnt", 64'({cpu_gnt, ext_gnt}), 64'd0);
      chk("rd_cpu_rvalid", 64'(cpu_rvalid), 64'(c == int'(RD_LAT) + 1));
      chk("rd_mem_wr", 64'(mem_wr), 64'd0);
    end
    chk("rd_cpu_rdata", cpu_rdata, D10);
    chk("rd_ext_rvalid", 64'(ext_rvalid), 64'd0);
    chk("rd_ext_rdata", ext_rdata, 64'd0);
    tick();
    smp();
    chk("erd_c0_ext_gnt", 64'(ext_gnt), 64'd1);
    exp_q.push_back('{own: 1'b1, data: D18});
    tick();
    ext_req = 1'b0;
    for (int c = 1; c <= int'(RD_LAT) + 1; c++) begin
      if (c > 1) tick();
      smp();
      chk("erd_ext_rvalid", 64'(ext_rvalid), 64'(c == int'(RD_LAT) + 1));
    end
    chk("erd_ext_rdata", ext_rdata, D18);
    chk("erd_cpu_rdata", cpu_rdata, D10);

    // Reset asserted in the middle of a read
    tick();
    cpu_req = 1'b1; cpu_addr = 64'h18;
    smp();
    chk("mrst_c0_cpu_gnt", 64'(cpu_gnt), 64'd1);
    tick();
    cpu_req = 1'b0;
    tick();
    #2 reset_ni = 1'b0; cpu_req = 1'b1;
    #1;
    chk("mrst_gnt", 64'({cpu_gnt, ext_gnt}), 64'd0);
    chk("mrst_rvalid", 64'({cpu_rvalid, ext_rvalid}), 64'd0);
    chk("mrst_mem_wr", 64'(mem_wr), 64'd0);
    chk("mrst_mem_addr", mem_addr, 64'd0);
    chk("mrst_mem_wdata", mem_wdata, 64'd0);
    chk("mrst_cpu_rdata", cpu_rdata, 64'd0);
    chk("mrst_ext_rdata", ext_rdata, 64'd0);
    tick();
    cpu_req = 1'b0;
    smp();
    #1 reset_ni = 1'b1;
    for (int c = 0; c < int'(RD_LAT) + 3; c++) begin
      tick();
      smp();
      chk("post_rst_quiet", 64'({cpu_rvalid, ext_rvalid, mem_wr, cpu_gnt, ext_gnt}), 64'd0);
    end

    // Both requesters hold reads continuously
    winner_ext = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h18;
    for (int i = 0; i < 4 * int'(P); i++) begin
      logic [1:0] exp_g;
      if (i > 0) tick();
      smp();
      exp_g = 2'b00;
      if ((i % int'(P)) == 0) exp_g = winner_ext ? 2'b01 : 2'b10;
      chk("tie_gnt", 64'({cpu_gnt, ext_gnt}), 64'(exp_g));
      if (exp_g != 2'b00) begin
        exp_q.push_back('{own: winner_ext, data: winner_ext ? D18 : D10});
`ifdef DMEM_ARB_RR_EN
        winner_ext = ~winner_ext;
`endif
      end
    end
    tick();
    cpu_req = 1'b0; ext_req = 1'b0;
    repeat (2) tick();
    smp();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
